// File: rtl/alu_ctrl_gen_pkg.sv
// Shared constants for the xgriscv ID/EX ALU control stage: ALU codes, branch codes,
// RV32I opcodes, buffer state encoding and small decode helpers.
package alu_ctrl_gen_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [3:0] ALU_CTRL_MOVEA = 4'b0000;
  localparam logic [3:0] ALU_CTRL_ADD   = 4'b0001;
  localparam logic [3:0] ALU_CTRL_SUB   = 4'b0011;
  localparam logic [3:0] ALU_CTRL_SLL   = 4'b0101;
  localparam logic [3:0] ALU_CTRL_SRL   = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SRA   = 4'b0111;
  localparam logic [3:0] ALU_CTRL_SLT   = 4'b1000;
  localparam logic [3:0] ALU_CTRL_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_CTRL_XOR   = 4'b1010;
  localparam logic [3:0] ALU_CTRL_OR    = 4'b1011;
  localparam logic [3:0] ALU_CTRL_AND   = 4'b1100;
  localparam logic [3:0] ALU_CTRL_LUI   = 4'b1101;
  localparam logic [3:0] ALU_CTRL_AUIPC = 4'b1110;
  localparam logic [3:0] ALU_CTRL_ZERO  = 4'b1111;

  localparam logic [2:0] ALU_BNONE = 3'b000;
  localparam logic [2:0] ALU_BEQ   = 3'b001;
  localparam logic [2:0] ALU_BNE   = 3'b010;
  localparam logic [2:0] ALU_BLT   = 3'b011;
  localparam logic [2:0] ALU_BGE   = 3'b100;
  localparam logic [2:0] ALU_BLTU  = 3'b101;
  localparam logic [2:0] ALU_BGEU  = 3'b110;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_e;

  typedef struct packed {
    logic [3:0] aluctrl;
    logic [2:0] aluctrl1;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{aluctrl: ALU_CTRL_ZERO, aluctrl1: ALU_BNONE, illegal: 1'b0};

  // alt selects SUB over ADD and SRA over SRL; it is ignored for the other funct3 values.
  function automatic logic [3:0] alu_op_sel(input logic [2:0] funct3, input logic alt);
    logic [3:0] code;
    case (funct3)
      3'b000:  code = alt ? ALU_CTRL_SUB : ALU_CTRL_ADD;
      3'b001:  code = ALU_CTRL_SLL;
      3'b010:  code = ALU_CTRL_SLT;
      3'b011:  code = ALU_CTRL_SLTU;
      3'b100:  code = ALU_CTRL_XOR;
      3'b101:  code = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
      3'b110:  code = ALU_CTRL_OR;
      default: code = ALU_CTRL_AND;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] branch_sel(input logic [2:0] funct3);
    logic [2:0] code;
    case (funct3)
      3'b000:  code = ALU_BEQ;
      3'b001:  code = ALU_BNE;
      3'b100:  code = ALU_BLT;
      3'b101:  code = ALU_BGE;
      3'b110:  code = ALU_BLTU;
      3'b111:  code = ALU_BGEU;
      default: code = ALU_BNONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decode into ALU operands and the aluctrl/aluctrl1 codes.
// Undecodable words pass rs1 through with MOVEA and flag illegal.
module alu_ctrl_dec
  import alu_ctrl_gen_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      aluctrl,
  output logic [2:0]      aluctrl1,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] shamt_ext;
  logic            is_shift_imm;
  logic            op_r_legal;
  logic            unused_fields;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign shamt_ext    = {{(XLEN-5){1'b0}}, instr[24:20]};
  assign is_shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign op_r_legal   = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  // Register specifiers are resolved upstream; only the operand values reach this stage.
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  always_comb begin
    a        = rs1_data;
    b        = '0;
    aluctrl  = ALU_CTRL_MOVEA;
    aluctrl1 = ALU_BNONE;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        if (op_r_legal) begin
          b       = rs2_data;
          aluctrl = alu_op_sel(funct3, funct7[5]);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        if (is_shift_imm) begin
          b       = shamt_ext;
          aluctrl = alu_op_sel(funct3, instr[30]);
        end else begin
          // ADDI must never become SUB even when imm[10] happens to be set.
          b       = imm;
          aluctrl = alu_op_sel(funct3, 1'b0);
        end
      end
      OP_LUI: begin
        a       = '0;
        b       = imm;
        aluctrl = ALU_CTRL_LUI;
      end
      OP_AUIPC: begin
        a       = pc;
        b       = imm;
        aluctrl = ALU_CTRL_AUIPC;
      end
      OP_LOAD, OP_STORE, OP_JALR: begin
        b       = imm;
        aluctrl = ALU_CTRL_ADD;
      end
      OP_JAL: begin
        a       = pc;
        b       = imm;
        aluctrl = ALU_CTRL_ADD;
      end
      OP_BRANCH: begin
        if (funct3[2:1] == 2'b01) begin
          illegal = 1'b1;
        end else begin
          b        = rs2_data;
          aluctrl  = ALU_CTRL_SUB;
          aluctrl1 = branch_sel(funct3);
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_gen.sv
// Registered ID/EX stage: decode on the input beat, two-entry skid buffer toward EX.
// state    | meaning
// ST_EMPTY | no beat held, ex_valid=0
// ST_ONE   | main holds a beat, skid free
// ST_TWO   | main and skid both hold beats, in_ready drops
module alu_ctrl_gen
  import alu_ctrl_gen_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      aluctrl,
  output logic [2:0]      aluctrl1,
  output logic            illegal
);

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  ctrl_t           dec_ctrl;

  buf_state_e      state;
  buf_state_e      state_nxt;
  logic            in_ready_q;
  logic            accept;
  logic            consume;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;

  logic [XLEN-1:0] main_a;
  logic [XLEN-1:0] main_b;
  ctrl_t           main_ctrl;
  logic [XLEN-1:0] skid_a;
  logic [XLEN-1:0] skid_b;
  ctrl_t           skid_ctrl;

  alu_ctrl_dec #(.XLEN(XLEN)) u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .a        (dec_a),
    .b        (dec_b),
    .aluctrl  (dec_ctrl.aluctrl),
    .aluctrl1 (dec_ctrl.aluctrl1),
    .illegal  (dec_ctrl.illegal)
  );

  assign accept  = in_valid && in_ready_q && !flush;
  assign consume = (state != ST_EMPTY) && ex_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_TWO);
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Branch redirect wins over any movement in the same cycle.
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_a    <= '0;
      main_b    <= '0;
      main_ctrl <= CTRL_RESET;
    end else if (load_main_in) begin
      main_a    <= dec_a;
      main_b    <= dec_b;
      main_ctrl <= dec_ctrl;
    end else if (load_main_skid) begin
      main_a    <= skid_a;
      main_b    <= skid_b;
      main_ctrl <= skid_ctrl;
    end
  end

  // Skid contents are only observed after a load, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_a    <= dec_a;
      skid_b    <= dec_b;
      skid_ctrl <= dec_ctrl;
    end
  end

  assign in_ready = in_ready_q;
  assign ex_valid = (state != ST_EMPTY);
  assign a        = main_a;
  assign b        = main_b;
  assign aluctrl  = main_ctrl.aluctrl;
  assign aluctrl1 = main_ctrl.aluctrl1;
  assign illegal  = main_ctrl.illegal;

endmodule

// File: tb/tb_alu_ctrl_gen.sv
// Self-checking bench for alu_ctrl_gen: FIFO-queue reference model plus directed literal checks.
module tb_alu_ctrl_gen;
  import alu_ctrl_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        ex_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
  logic        in_ready, ex_valid, illegal;
  logic [31:0] a, b;
  logic [3:0]  aluctrl;
  logic [2:0]  aluctrl1;

  always #5 clk = ~clk;

  alu_ctrl_gen #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .a(a), .b(b),
    .aluctrl(aluctrl), .aluctrl1(aluctrl1), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [2:0]  br;
    logic        ill;
  } beat_t;

  beat_t q[$];
  logic  m_rdy = 1'b1;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] arith(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_CTRL_ADD;
      3'd1: return ALU_CTRL_SLL;
      3'd2: return ALU_CTRL_SLT;
      3'd3: return ALU_CTRL_SLTU;
      3'd4: return ALU_CTRL_XOR;
      3'd5: return ALU_CTRL_SRL;
      3'd6: return ALU_CTRL_OR;
      default: return ALU_CTRL_AND;
    endcase
  endfunction

  function automatic beat_t ref_dec(input logic [31:0] i, p, r1, r2, im);
    beat_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    r = '{r1, 32'h0, ALU_CTRL_MOVEA, 3'b000, 1'b1};
    case (i[6:0])
      7'b0110011: begin
        if (f7 == 7'h00) r = '{r1, r2, arith(f3), 3'b000, 1'b0};
        else if (f7 == 7'h20 && f3 == 3'd0) r = '{r1, r2, ALU_CTRL_SUB, 3'b000, 1'b0};
        else if (f7 == 7'h20 && f3 == 3'd5) r = '{r1, r2, ALU_CTRL_SRA, 3'b000, 1'b0};
      end
      7'b0010011: begin
        if (f3 == 3'd1) r = '{r1, {27'b0, i[24:20]}, ALU_CTRL_SLL, 3'b000, 1'b0};
        else if (f3 == 3'd5)
          r = '{r1, {27'b0, i[24:20]}, (i[30] ? ALU_CTRL_SRA : ALU_CTRL_SRL), 3'b000, 1'b0};
        else r = '{r1, im, arith(f3), 3'b000, 1'b0};
      end
      7'b0110111: r = '{32'h0, im, ALU_CTRL_LUI, 3'b000, 1'b0};
      7'b0010111: r = '{p, im, ALU_CTRL_AUIPC, 3'b000, 1'b0};
      7'b0000011, 7'b0100011, 7'b1100111: r = '{r1, im, ALU_CTRL_ADD, 3'b000, 1'b0};
      7'b1101111: r = '{p, im, ALU_CTRL_ADD, 3'b000, 1'b0};
      7'b1100011: begin
        case (f3)
          3'd0: r = '{r1, r2, ALU_CTRL_SUB, ALU_BEQ, 1'b0};
          3'd1: r = '{r1, r2, ALU_CTRL_SUB, ALU_BNE, 1'b0};
          3'd4: r = '{r1, r2, ALU_CTRL_SUB, ALU_BLT, 1'b0};
          3'd5: r = '{r1, r2, ALU_CTRL_SUB, ALU_BGE, 1'b0};
          3'd6: r = '{r1, r2, ALU_CTRL_SUB, ALU_BLTU, 1'b0};
          3'd7: r = '{r1, r2, ALU_CTRL_SUB, ALU_BGEU, 1'b0};
          default: ;
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  // Reference FIFO: holds what EX must see, in order, capacity two.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_rdy = 1'b1;
    end else begin
      logic acc, con;
      acc = in_valid && m_rdy && !flush;
      con = (q.size() != 0) && ex_ready;
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(ref_dec(instr, pc, rs1_data, rs2_data, imm));
      end
      m_rdy = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("ex_valid", ex_valid, (q.size() != 0));
      check("in_ready", in_ready, m_rdy);
      if (q.size() != 0) begin
        check("a", a, q[0].a);
        check("b", b, q[0].b);
        check("aluctrl", aluctrl, q[0].ctrl);
        check("aluctrl1", aluctrl1, q[0].br);
        check("illegal", illegal, q[0].ill);
      end
    end
  end

  task automatic send(input logic [31:0] i, p, r1, r2, im);
    int   k;
    logic ok;
    k = 0;
    instr = i; pc = p; rs1_data = r1; rs2_data = r2; imm = im;
    in_valid = 1'b1;
    do begin
      ok = in_ready;
      @(negedge clk);
      k++;
    end while (!ok && k < 50);
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ex_valid"}, ex_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_a"}, a, 32'h0);
    check({tag, "_b"}, b, 32'h0);
    check({tag, "_aluctrl"}, aluctrl, ALU_CTRL_ZERO);
    check({tag, "_aluctrl1"}, aluctrl1, 3'b000);
    check({tag, "_illegal"}, illegal, 1'b0);
  endtask

  logic [31:0] vec [30];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec = '{32'h002081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3,
            32'h0020D1B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h022081B3,
            32'h402091B3, 32'hC0008093, 32'h01F09093, 32'h0040D093, 32'h123450B7,
            32'h0040A083, 32'h0020A223, 32'h008000EF, 32'h000080E7, 32'h00208463,
            32'h00209463, 32'h0020C463, 32'h0020D463, 32'h0020F463, 32'h0020A463,
            32'h0000007F, 32'h4030D093, 32'h00003013, 32'h0020E013, 32'h40208133};
    ex_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rstn = 1'b1;

    send(32'h40208133, 32'h0, 32'd5, 32'd7, 32'h0);
    check("sub_valid", ex_valid, 1'b1);
    check("sub_ctrl", aluctrl, ALU_CTRL_SUB);
    check("sub_br", aluctrl1, 3'b000);
    check("sub_a", a, 32'd5);
    check("sub_b", b, 32'd7);

    send(32'h4030D093, 32'h0, 32'h80, 32'h0, 32'h403);
    check("srai_ctrl", aluctrl, ALU_CTRL_SRA);
    check("srai_b", b, 32'd3);

    send({7'b0, 5'd2, 5'd1, 3'b110, 5'b0, 7'b1100011}, 32'h0, 32'h10, 32'h20, 32'h0);
    check("bltu_br", aluctrl1, ALU_BLTU);
    check("bltu_ctrl", aluctrl, ALU_CTRL_SUB);

    send({20'h2, 5'd3, 7'b0010111}, 32'h1000, 32'h55, 32'h66, 32'h2000);
    check("auipc_a", a, 32'h1000);
    check("auipc_b", b, 32'h2000);

    send(32'h0000007F, 32'h0, 32'hABCD, 32'h1234, 32'h77);
    check("ill_flag", illegal, 1'b1);
    check("ill_ctrl", aluctrl, ALU_CTRL_MOVEA);
    check("ill_b", b, 32'h0);
    check("ill_a", a, 32'hABCD);

    for (int i = 0; i < 30; i++) begin
      ex_ready = (i % 3 != 2);
      send(vec[i], 32'h400 + 32'(i) * 4, 32'h100 + 32'(i) * 17, 32'hFFFF_FFF0 - 32'(i),
           {{20{vec[i][31]}}, vec[i][31:20]});
    end
    ex_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Backpressure: three beats offered back to back while EX stalls.
    ex_ready = 1'b0;
    instr = 32'h002081B3; rs1_data = 32'h11; rs2_data = 32'h1; in_valid = 1'b1;
    @(negedge clk);
    instr = 32'h0020C1B3; rs1_data = 32'h22; rs2_data = 32'h2;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    instr = 32'h0020E1B3; rs1_data = 32'h33; rs2_data = 32'h3;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_hold_a", a, 32'h11);
    ex_ready = 1'b1;
    @(negedge clk);
    check("bp_second_a", a, 32'h22);
    check("bp_in_ready_back", in_ready, 1'b1);
    @(negedge clk);
    check("bp_drained", ex_valid, 1'b0);

    // Flush with a full buffer and a concurrent offer.
    ex_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'h44, 32'h4, 32'h0);
    send(32'h002081B3, 32'h0, 32'h55, 32'h5, 32'h0);
    instr = 32'h002081B3; rs1_data = 32'h66; flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", ex_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_stays_empty", ex_valid, 1'b0);
    end

    // Flush from one entry while in_ready is high and a beat is offered.
    ex_ready = 1'b0;
    send(32'h0020F1B3, 32'h0, 32'h77, 32'h7, 32'h0);
    instr = 32'h0020F1B3; rs1_data = 32'h88; flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_valid", ex_valid, 1'b0);
    @(negedge clk);
    check("flush1_stays_empty", ex_valid, 1'b0);

    // Asynchronous reset between clock edges with a beat held.
    send(32'h123450B7, 32'h0, 32'h9, 32'h9, 32'h12345000);
    check("pre_rst_valid", ex_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    ex_ready = 1'b1;
    send(32'h002081B3, 32'h0, 32'hBEEF, 32'h1, 32'h0);
    check("post_rst_a", a, 32'hBEEF);
    check("post_rst_ctrl", aluctrl, ALU_CTRL_ADD);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_gen.md
# alu_ctrl_gen

Registered ID/EX decode stage for the xgriscv core. It accepts a decoded-issue instruction word with its operands and encodes the `aluctrl`/`aluctrl1` control fields and the final `a`/`b` operands that the combinational ALU consumes. It contains a two-entry skid buffer with valid/ready handshakes on both sides, so `in_ready` is a registered signal. Flush support is provided for branch redirect.

## Interface
- `XLEN`, default 32: datapath width; must match the `` `XLEN `` define.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `flush` in 1: discard all buffered entries and the incoming beat.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: the buffer can accept a beat. Registered.
- `instr` in 32: RV32I instruction word.
- `pc` in XLEN: instruction address.
- `rs1_data` in XLEN: register-file read port 1.
- `rs2_data` in XLEN: register-file read port 2.
- `imm` in XLEN: sign-extended immediate from the immediate generator.
- `ex_valid` out 1: output beat valid.
- `ex_ready` in 1: EX stage accepts the beat.
- `a`, `b` out XLEN: ALU operands.
- `aluctrl` out 4: `` `ALU_CTRL_* `` code.
- `aluctrl1` out 3: `` `ALU_B* `` branch code. 3'b000 means not a branch.
- `illegal` out 1: the instruction was not decodable.

## Operation
**Decode.** Decode is combinational on the input beat. The result is written into the buffer on acceptance.
- OP (0110011), selected by funct3/funct7[5]:
  - ADD / SUB → `ALU_CTRL_ADD` / `ALU_CTRL_SUB`
  - SLL, SLT, SLTU, XOR, OR, AND → the matching code
  - SRL / SRA → `ALU_CTRL_SRL` / `ALU_CTRL_SRA`
  - Operands: a=rs1, b=rs2.
- OP-IMM (0010011): same mapping as OP with b=imm.
  - ADDI always maps to ADD.
  - For shifts, b={XLEN-5 zeros, instr[24:20]}. SRAI is selected by instr[30].
- LUI: a=0, b=imm, `ALU_CTRL_LUI`.
- AUIPC: a=pc, b=imm, `ALU_CTRL_AUIPC`.
- LOAD, STORE, JALR: a=rs1, b=imm, `ALU_CTRL_ADD`.
- JAL: a=pc, b=imm, `ALU_CTRL_ADD`.
- BRANCH: a=rs1, b=rs2, aluctrl=`ALU_CTRL_SUB`. funct3 maps to aluctrl1 as follows:
  - 000 → BEQ, 001 → BNE
  - 100 → BLT, 101 → BGE
  - 110 → BLTU, 111 → BGEU
- aluctrl1 is 000 for every non-branch instruction.
- **Illegal** cases:
  - any other opcode
  - OP with funct7 ∉ {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {000, 101}
  - BRANCH with funct3 010 or 011
  - For these: illegal=1, aluctrl=`ALU_CTRL_MOVEA`, aluctrl1=000, a=rs1, b=0.

**Buffer.** There are two entries: `main` drives the outputs and `skid` holds the overflow.
- A beat is accepted when in_valid && in_ready && !flush.
- EX consumes a beat when ex_valid && ex_ready.
- States and transitions (EMPTY / ONE / TWO):
  - EMPTY→ONE on accept.
  - ONE→EMPTY on consume without accept.
  - ONE→ONE on simultaneous accept and consume; main is replaced by the new beat.
  - ONE→TWO on accept without consume; the new beat goes to skid.
  - TWO→ONE on consume; skid moves to main.
- `in_ready` is the registered value of state≠TWO.
- Ordering is strictly FIFO.
- `flush` forces EMPTY on the next edge and drops any beat offered in the same cycle. Flush has priority over accept and consume.

## Timing
- Latency: an accepted beat appears on the outputs one cycle after acceptance, provided it enters an empty main entry.
- Throughput: one beat per cycle while ex_ready=1.
- Handshake rules:
  - ex_valid is held and a/b/aluctrl/aluctrl1/illegal stay stable while ex_valid && !ex_ready.
  - in_ready never depends combinationally on ex_ready.
- Reset (rstn low, asynchronous): state=EMPTY, ex_valid=0, in_ready=1, a=0, b=0, aluctrl=`ALU_CTRL_ZERO`, aluctrl1=000, illegal=0.
- Reset release is taken at the next rising edge.
- Reset asserted mid-transfer drops both entries.
- Payload registers need no reset beyond the values above. Output payload is don't-care when ex_valid=0, but must equal the reset values immediately after reset.

## Structure
- The `` `ALU_CTRL_* ``, `` `ALU_B* `` and `` `XLEN `` codes come from the shared `xgriscv_defines.v`.
- Add opcode constants `OP_R`, `OP_IMM`, `OP_LUI`, `OP_AUIPC`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR` to the same file.
- One natural sub-module: `alu_ctrl_dec`, the purely combinational decode from {instr, pc, rs1_data, rs2_data, imm} to {a, b, aluctrl, aluctrl1, illegal}.
- The buffer and state logic stay in the top module.

## Test plan
- **Register ops:** instr 0x40208133 (sub), rs1=5, rs2=7, ex_ready=1 → next cycle ex_valid=1, aluctrl=`ALU_CTRL_SUB`, aluctrl1=000, a=5, b=7.
- **Shift immediate:** instr 0x4030D093 (srai x1,x1,3), imm=0x403 → aluctrl=`ALU_CTRL_SRA`, b=3.
- **Branch and upper-immediate:**
  - bltu (funct3=110) → aluctrl1=`ALU_BLTU`, aluctrl=`ALU_CTRL_SUB`.
  - auipc with pc=0x1000, imm=0x2000 → a=0x1000, b=0x2000.
- **Backpressure:** hold ex_ready=0 and offer 3 beats → only 2 are accepted, in_ready=0 the cycle after the second. Raise ex_ready → outputs appear in order, then in_ready=1.
- **Flush with a full buffer and a concurrent in_valid** → next cycle ex_valid=0, in_ready=1, and none of the three beats appears later.
- **Illegal instruction:** opcode 0x7F → illegal=1, aluctrl=`ALU_CTRL_MOVEA`.
- **Async reset mid-stream:** outputs take their reset values without waiting for a clock edge, then normal accept resumes after release.
